// File: rtl/rapcore_wb_cmd_bridge_if.sv
// Wishbone classic slave bundle for the rapcore command bridge.
// Signal names follow the Caravel user-area bus.
interface rapcore_wb_cmd_bridge_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rapcore_wb_cmd_bridge.sv
// Wishbone slave feeding rapcore commands through a FWFT FIFO,
// with response capture and FIFO status readback.
module rapcore_wb_cmd_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  rapcore_wb_cmd_bridge_if.slave wb,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [31:0] resp_data,
  input  logic        resp_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          en;
  logic          ovf;
  logic          pend;
  logic [31:0]   resp;

  logic          req;
  logic          hit;
  logic [7:0]    off;
  logic          wr;
  logic          rd;
  logic          a_ctrl;
  logic          a_stat;
  logic          a_cmd;
  logic          a_resp;
  logic          flush;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          empty;
  logic          full;
  logic [31:0]   rdata;

  assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign hit    = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign off    = wb.wbs_adr_i[7:0];
  assign wr     = req & wb.wbs_we_i & hit;
  assign rd     = req & ~wb.wbs_we_i & hit;
  assign a_ctrl = off == 8'h00;
  assign a_stat = off == 8'h04;
  assign a_cmd  = off == 8'h08;
  assign a_resp = off == 8'h0C;

  assign empty   = level == '0;
  assign full    = level == LW'(DEPTH);
  assign flush   = wr & a_ctrl & wb.wbs_dat_i[1];
  assign push    = wr & a_cmd & (wb.wbs_sel_i == 4'hF);
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign pop     = cmd_valid & cmd_ready;
  assign push_ok = push & (~full | pop);

  assign cmd_valid = en & ~empty;
  assign cmd_data  = mem[rd_ptr];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a_ctrl: rdata[0] = en;
      a_stat: begin
        rdata[0]      = empty;
        rdata[1]      = full;
        rdata[2]      = ovf;
        rdata[3]      = pend;
        rdata[8 +: LW] = level;
      end
      a_resp: rdata = resp;
      default: rdata = '0;
    endcase
    if (!hit) rdata = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wb.wbs_dat_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      en  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (wr & a_ctrl & wb.wbs_sel_i[0]) en <= wb.wbs_dat_i[0];
      if (push & ~push_ok) ovf <= 1'b1;
      else if (wr & a_stat & wb.wbs_sel_i[0] & wb.wbs_dat_i[2])
        ovf <= 1'b0;
    end
  end

  // A fresh response wins over a concurrent readback clearing PEND
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      resp <= '0;
      pend <= 1'b0;
    end else if (resp_valid) begin
      resp <= resp_data;
      pend <= 1'b1;
    end else if (rd & a_resp) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= req;
      if (req) wb.wbs_dat_o <= wb.wbs_we_i ? '0 : rdata;
    end
  end

endmodule

// File: tb/tb_rapcore_wb_cmd_bridge.sv
// Bench for rapcore_wb_cmd_bridge: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rapcore_wb_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] resp_data = '0;
  logic        resp_valid = 1'b0;

  rapcore_wb_cmd_bridge_if wb ();

  rapcore_wb_cmd_bridge dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb.slave),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .resp_data  (resp_data),
    .resp_valid (resp_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;
  bit rnd_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus the visible flags
  logic [31:0] q[$];
  logic        m_en, m_ovf, m_pend, m_ack;
  logic [31:0] m_resp, m_dat;

  always @(posedge clk) begin
    logic        req, hit, pop, wr;
    logic [7:0]  off;
    logic [31:0] rv;
    int          sz;
    if (rst) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_pend = 0; m_ack = 0;
      m_resp = 0; m_dat = 0;
    end else begin
      req = wb.wbs_cyc_i && wb.wbs_stb_i && !m_ack;
      hit = wb.wbs_adr_i[31:8] == 24'h300000;
      off = wb.wbs_adr_i[7:0];
      sz  = q.size();
      rv  = 0;
      if (hit && off == 8'h00) rv = {31'b0, m_en};
      if (hit && off == 8'h04)
        rv = (32'(sz) << 8) | (32'(m_pend) << 3) | (32'(m_ovf) << 2)
           | (32'(sz == 8) << 1) | 32'(sz == 0);
      if (hit && off == 8'h0C) rv = m_resp;
      pop = m_en && sz > 0 && cmd_ready;
      wr  = req && wb.wbs_we_i && hit;
      if (wr && off == 8'h00 && wb.wbs_dat_i[1]) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (wr && off == 8'h08 && wb.wbs_sel_i == 4'hF) begin
          if (sz < 8 || pop) q.push_back(wb.wbs_dat_i);
          else m_ovf = 1;
        end
      end
      if (wr && off == 8'h00 && wb.wbs_sel_i[0]) m_en = wb.wbs_dat_i[0];
      if (wr && off == 8'h04 && wb.wbs_sel_i[0] && wb.wbs_dat_i[2])
        m_ovf = 0;
      if (resp_valid) begin
        m_resp = resp_data;
        m_pend = 1;
      end else if (req && !wb.wbs_we_i && hit && off == 8'h0C) m_pend = 0;
      if (req) m_dat = wb.wbs_we_i ? 32'h0 : rv;
      m_ack = req;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_on) begin
      check("ack", {31'b0, wb.wbs_ack_o}, {31'b0, m_ack});
      check("cmd_valid", {31'b0, cmd_valid},
            {31'b0, m_en && q.size() > 0});
      if (q.size() > 0) check("cmd_data", cmd_data, q[0]);
      if (m_ack) check("rd_data", wb.wbs_dat_o, m_dat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_on) begin
      cmd_ready  = $urandom_range(0, 1) == 1;
      resp_valid = $urandom_range(0, 7) == 0;
      resp_data  = $urandom;
    end
  endtask

  task automatic bus(input logic [31:0] adr, input logic we,
                     input logic [3:0] sel, input logic [31:0] dat,
                     output logic [31:0] rd);
    int n = 0;
    wb.wbs_adr_i = adr;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    wb.wbs_cyc_i = 1;
    wb.wbs_stb_i = 1;
    do begin
      tick();
      n++;
    end while (!wb.wbs_ack_o && n < 16);
    if (!wb.wbs_ack_o) check("ack_timeout", 0, 1);
    rd = wb.wbs_dat_o;
    wb.wbs_cyc_i = 0;
    wb.wbs_stb_i = 0;
    tick();
    check("ack_one_cycle", {31'b0, wb.wbs_ack_o}, 0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam logic [31:0] B = 32'h3000_0000;
  vec_t tbl[25];
  logic [31:0] r;

  initial begin
    tbl[0]  = '{B+4,  0, 4'hF, 0,            1, 32'h1};
    tbl[1]  = '{B+12, 0, 4'hF, 0,            1, 32'h0};
    tbl[2]  = '{B+0,  1, 4'hF, 32'h1,        0, 0};
    tbl[3]  = '{B+8,  1, 4'hF, 32'hA5A5_0001, 0, 0};
    tbl[4]  = '{B+8,  1, 4'hF, 32'hA5A5_0002, 0, 0};
    tbl[5]  = '{B+8,  1, 4'hF, 32'hA5A5_0003, 0, 0};
    tbl[6]  = '{B+4,  0, 4'hF, 0,            1, 32'h300};
    tbl[7]  = '{B+0,  0, 4'hF, 0,            1, 32'h1};
    tbl[8]  = '{B+8,  1, 4'h3, 32'h1234,     0, 0};
    tbl[9]  = '{B+4,  0, 4'hF, 0,            1, 32'h300};
    tbl[10] = '{B+0,  1, 4'hF, 32'h0,        0, 0};
    for (int i = 0; i < 6; i++)
      tbl[11+i] = '{B+8, 1, 4'hF, 32'hB000_0000 + i, 0, 0};
    tbl[17] = '{B+4,  0, 4'hF, 0,            1, 32'h806};
    tbl[18] = '{B+4,  1, 4'hF, 32'h4,        0, 0};
    tbl[19] = '{B+4,  0, 4'hF, 0,            1, 32'h802};
    tbl[20] = '{B+8,  0, 4'hF, 0,            1, 32'h0};
    tbl[21] = '{B+32'h100, 0, 4'hF, 0,       1, 32'h0};
    tbl[22] = '{B+32'h108, 1, 4'hF, 32'h77,  0, 0};
    tbl[23] = '{B+4,  0, 4'hF, 0,            1, 32'h802};
    tbl[24] = '{B+32'h10, 0, 4'hF, 0,        1, 32'h0};

    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
    wb.wbs_sel_i = 0; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;
    repeat (3) tick();
    rst = 0;
    check("rst_ack", {31'b0, wb.wbs_ack_o}, 0);
    check("rst_dat", wb.wbs_dat_o, 0);
    check("rst_valid", {31'b0, cmd_valid}, 0);
    check("rst_cmd_data", cmd_data, 0);
    chk_on = 1;

    for (int i = 0; i < 25; i++) begin
      bus(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, r);
      if (tbl[i].chk) check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end
    check("head_after_tbl", cmd_data, 32'hA5A5_0001);

    // Full FIFO: push lands on the same edge as a pop
    bus(B+0, 1, 4'hF, 32'h1, r);
    wb.wbs_adr_i = B+8; wb.wbs_we_i = 1; wb.wbs_sel_i = 4'hF;
    wb.wbs_dat_i = 32'hC0DE_0000;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1;
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    check("push_pop_ack", {31'b0, wb.wbs_ack_o}, 1);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    tick();
    check("head_after_pop", cmd_data, 32'hA5A5_0002);
    bus(B+4, 0, 4'hF, 0, r);
    check("full_no_ovf", r, 32'h802);

    bus(B+0, 1, 4'hF, 32'h3, r);
    check("flush_valid", {31'b0, cmd_valid}, 0);
    bus(B+4, 0, 4'hF, 0, r);
    check("flush_status", r, 32'h1);
    bus(B+0, 0, 4'hF, 0, r);
    check("flush_en", r, 32'h1);

    for (int i = 0; i < 3; i++) bus(B+8, 1, 4'hF, 32'hD0 + i, r);
    cmd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("emit_valid", {31'b0, cmd_valid}, 1);
      check("emit_data", cmd_data, 32'hD0 + i);
      tick();
    end
    cmd_ready = 0;
    check("emit_empty", {31'b0, cmd_valid}, 0);

    resp_data = 32'hDEAD_BEEF; resp_valid = 1;
    tick();
    resp_valid = 0;
    bus(B+4, 0, 4'hF, 0, r);
    check("resp_pend", r, 32'h9);
    bus(B+12, 0, 4'hF, 0, r);
    check("resp_read", r, 32'hDEAD_BEEF);
    bus(B+4, 0, 4'hF, 0, r);
    check("resp_cleared", r, 32'h1);

    // Response strobe colliding with the RESP read edge
    resp_data = 32'h1111_1111; resp_valid = 1;
    tick();
    resp_valid = 0;
    wb.wbs_adr_i = B+12; wb.wbs_we_i = 0; wb.wbs_sel_i = 4'hF;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1;
    resp_data = 32'h2222_2222; resp_valid = 1;
    tick();
    resp_valid = 0;
    check("coll_old", wb.wbs_dat_o, 32'h1111_1111);
    wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    tick();
    bus(B+4, 0, 4'hF, 0, r);
    check("coll_pend", r, 32'h9);
    bus(B+12, 0, 4'hF, 0, r);
    check("coll_new", r, 32'h2222_2222);

    bus(B+8, 1, 4'hF, 32'hEE, r);
    wb.wbs_adr_i = B+4; wb.wbs_we_i = 0;
    wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1;
    tick();
    rst = 1; wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0;
    tick();
    rst = 0;
    check("midrst_ack", {31'b0, wb.wbs_ack_o}, 0);
    check("midrst_valid", {31'b0, cmd_valid}, 0);
    bus(B+4, 0, 4'hF, 0, r);
    check("midrst_status", r, 32'h1);

    rnd_on = 1;
    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 15);
      logic [31:0] d = $urandom;
      if (op < 7) bus(B+8, 1, ($urandom_range(0, 5) == 0) ? 4'h7 : 4'hF, d, r);
      else if (op == 7) bus(B+0, 1, 4'hF, {30'b0, $urandom_range(0, 9) == 0, 1'b1}, r);
      else if (op == 8) bus(B+0, 1, 4'hF, {31'b0, d[0]}, r);
      else if (op == 9) bus(B+4, 1, 4'hF, d, r);
      else if (op < 13) bus(B+4, 0, 4'hF, 0, r);
      else if (op == 13) bus(B+12, 0, 4'hF, 0, r);
      else if (op == 14) bus(B+0, 0, 4'hF, 0, r);
      else bus(B + {24'h0, d[7:0]}, d[8], 4'hF, d, r);
    end
    rnd_on = 0;
    cmd_ready = 0; resp_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rapcore_wb_cmd_bridge.md
# rapcore_wb_cmd_bridge

Wishbone slave that sits between the Caravel management SoC bus and the rapcore motion core, directly upstream of rapcore's command input. It decodes the user-area Wishbone window, pushes 32-bit command words into a first-word-fall-through FIFO and presents them to rapcore as a valid/ready stream. It also captures rapcore responses for readback and exposes FIFO status. This gives the SoC a non-blocking command path in place of the tied-off bus.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: window base; match on wbs_adr_i[31:8].
- DEPTH, 8: FIFO depth in words (power of 2, ≥2); LW = clog2(DEPTH)+1.

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  registered read data
- cmd_data  out  32  FIFO head word
- cmd_valid  out  1  command available
- cmd_ready  in  1  rapcore accepts command
- resp_data  in  32  rapcore response word
- resp_valid  in  1  one-cycle response strobe

## Operation
- req = cyc & stb & ~wbs_ack_o. On a req edge, access is performed and wbs_ack_o = 1 next cycle for exactly one cycle; back-to-back requests are acked every other cycle.
- Every req is acked, including out-of-window and unmapped addresses (read 0, write ignored); the bus never hangs.
- Register map (offset = wbs_adr_i[7:0]):
  - 0x00 CTRL R/W: bit0 EN (write only if sel[0]); bit1 FLUSH write-1 one-shot, reads 0.
  - 0x04 STATUS R/W1C: bit0 EMPTY, bit1 FULL, bit2 OVF (sticky), bit3 RESP_PEND, [8+LW-1:8] LEVEL. Writing 1 to bit2 (sel[0]) clears OVF; other bits read-only.
  - 0x08 CMD W: pushes wbs_dat_i when sel==4'hF; partial-select writes are acked and dropped without setting OVF. Reads 0.
  - 0x0C RESP R: last captured resp_data; a read clears RESP_PEND.
- FIFO: FWFT; cmd_data = head word; cmd_valid = EN & ~EMPTY. pop = cmd_valid & cmd_ready.
- Push accepted if ~FULL or pop in the same cycle; otherwise dropped and OVF set.
- Simultaneous push and pop: level unchanged, both pointers advance.
- FLUSH: pointers and level to 0 in that cycle; a same-cycle pop is discarded; flush has priority over any concurrent push (no push can coincide since both are bus writes).
- EN = 0 holds the FIFO contents; cmd_valid stays 0 and pushes still accepted.
- Response: resp_valid loads RESP and sets RESP_PEND. If resp_valid coincides with a RESP read, the new data is stored and RESP_PEND remains 1; the read returns the old value.
- Pointers wrap modulo DEPTH; LEVEL saturates logically at DEPTH (FULL = LEVEL==DEPTH).

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, cmd_valid 0, cmd_data undefined-free (0 after reset), EN 0, OVF 0, RESP_PEND 0, RESP 0, LEVEL 0, EMPTY 1, FULL 0.
- Reset mid-transaction: ack dropped, FIFO emptied; the SoC re-issues.
- Write latency: CMD pushed on the req edge; cmd_valid visible the same cycle wbs_ack_o is high (1 cycle after req) when EN=1.
- Read data is sampled on the req edge and valid while wbs_ack_o = 1; STATUS reflects state before that edge.
- cmd_data/cmd_valid change only on clock edges; no combinational path from cmd_ready to cmd_valid.

## Test plan
- Reset, read 0x04 -> 0x0000_0001 (EMPTY only); read 0x0C -> 0; every ack one cycle wide.
- EN=1, write 0xA5A5_0001, 0x…0002, 0x…0003 to 0x08 with cmd_ready=0 -> LEVEL=3, cmd_data=0xA5A5_0001; raise cmd_ready -> words emitted in order, one per cycle, then EMPTY=1.
- Push DEPTH+1 words with EN=0 -> STATUS FULL=1, OVF=1, LEVEL=8; write 0x04 data 0x4 -> OVF=0, FULL stays 1.
- FULL with cmd_ready=1, EN=1, push during a pop -> accepted, LEVEL stays 8, OVF stays 0.
- Write CTRL 0x3 with 5 queued -> LEVEL=0, EMPTY=1, cmd_valid=0 next cycle, EN reads back 1.
- resp_valid with 0xDEAD_BEEF -> RESP_PEND=1; read 0x0C -> 0xDEAD_BEEF, RESP_PEND=0; read 0x3000_0100 (out of window) -> acked, data 0.
